// File: rtl/pipelined_rca_adder_pkg.sv
// Shared constants for the pipelined ripple-carry adder: stage count,
// parameter legality check and operation encoding.
package pipelined_rca_adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    function automatic int adder_nstage(input int width, input int slice);
        return (slice < 1) ? 0 : width / slice;
    endfunction

    function automatic bit adder_params_ok(input int width, input int slice);
        return (slice >= 1) && (width >= slice) && ((width % slice) == 0);
    endfunction

endpackage

// File: rtl/pipelined_rca_adder_slice.sv
// One SLICE-bit combinational ripple add; also exposes the carry into the
// top bit so the last stage can form signed overflow.
module adder_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o,
    output logic         cmsb_o
);

    logic [W:0] c_w;

    always_comb begin
        c_w   = '0;
        sum_o = '0;
        c_w[0] = cin_i;
        for (int i = 0; i < W; i++) begin
            sum_o[i]  = a_i[i] ^ b_i[i] ^ c_w[i];
            c_w[i+1]  = (a_i[i] & b_i[i]) | (c_w[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign cout_o = c_w[W];
    assign cmsb_o = c_w[W-1];

endmodule

// File: rtl/pipelined_rca_adder.sv
// Ripple-carry adder/subtractor split into NSTAGE pipeline stages of SLICE
// bits each, with valid/ready flow control and a global stall.
module pipelined_rca_adder
    import pipelined_rca_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSTAGE = adder_nstage(WIDTH, SLICE);

    if (!adder_params_ok(WIDTH, SLICE)) begin : g_bad_params
        $error("pipelined_rca_adder: WIDTH must be a non-zero multiple of SLICE");
    end

    logic             valid_q [NSTAGE];
    logic             carry_q [NSTAGE];
    logic [WIDTH-1:0] sum_q   [NSTAGE];
    logic [WIDTH-1:0] a_q     [NSTAGE];
    logic [WIDTH-1:0] b_q     [NSTAGE];
    logic             ovf_q;

    logic             valid_d [NSTAGE];
    logic [WIDTH-1:0] a_d     [NSTAGE];
    logic [WIDTH-1:0] b_d     [NSTAGE];
    logic [WIDTH-1:0] sum_d   [NSTAGE];
    logic             ovf_d;

    logic             cin_w       [NSTAGE];
    logic [WIDTH-1:0] sum_in_w    [NSTAGE];
    logic [SLICE-1:0] slice_sum_w [NSTAGE];
    logic             slice_co_w  [NSTAGE];
    logic             slice_cm_w  [NSTAGE];

    op_e              op_w;
    logic [WIDTH-1:0] b_eff_w;
    logic             cin_eff_w;
    logic             stall_w;

    // Subtraction is a + ~b + 1; b is inverted once at the input and carried
    // in its inverted form through the skew registers.
    assign op_w      = op_e'(sub);
    assign b_eff_w   = (op_w == OP_SUB) ? ~b : b;
    assign cin_eff_w = (op_w == OP_SUB) ? 1'b1 : cin;

    assign stall_w   = out_valid && !out_ready;
    assign in_ready  = !stall_w;

    always_comb begin
        valid_d[0]  = in_valid;
        a_d[0]      = a;
        b_d[0]      = b_eff_w;
        cin_w[0]    = cin_eff_w;
        sum_in_w[0] = '0;
        for (int k = 1; k < NSTAGE; k++) begin
            valid_d[k]  = valid_q[k-1];
            a_d[k]      = a_q[k-1];
            b_d[k]      = b_q[k-1];
            cin_w[k]    = carry_q[k-1];
            sum_in_w[k] = sum_q[k-1];
        end
    end

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        adder_slice #(.W(SLICE)) u_slice (
            .a_i    (a_d[k][k*SLICE +: SLICE]),
            .b_i    (b_d[k][k*SLICE +: SLICE]),
            .cin_i  (cin_w[k]),
            .sum_o  (slice_sum_w[k]),
            .cout_o (slice_co_w[k]),
            .cmsb_o (slice_cm_w[k])
        );
    end

    always_comb begin
        for (int k = 0; k < NSTAGE; k++) begin
            sum_d[k] = sum_in_w[k];
            sum_d[k][k*SLICE +: SLICE] = slice_sum_w[k];
        end
    end

    assign ovf_d = slice_co_w[NSTAGE-1] ^ slice_cm_w[NSTAGE-1];

    // A stall freezes the whole pipe, so one enable covers every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NSTAGE; k++) begin
                valid_q[k] <= 1'b0;
                carry_q[k] <= 1'b0;
                sum_q[k]   <= '0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
            end
            ovf_q <= 1'b0;
        end else if (!stall_w) begin
            for (int k = 0; k < NSTAGE; k++) begin
                valid_q[k] <= valid_d[k];
                carry_q[k] <= slice_co_w[k];
                sum_q[k]   <= sum_d[k];
                a_q[k]     <= a_d[k];
                b_q[k]     <= b_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = valid_q[NSTAGE-1];
    assign sum       = sum_q[NSTAGE-1];
    assign cout      = carry_q[NSTAGE-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Self-checking bench for pipelined_rca_adder (WIDTH=16, SLICE=4).
module tb_pipelined_rca_adder;

    localparam int NSTAGE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    res_t exp_q[$];

    logic [15:0] dir_a  [6] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0005, 16'h00FF, 16'h8000};
    logic [15:0] dir_b  [6] = '{16'h0001, 16'h0001, 16'h0001, 16'h0007, 16'h0000, 16'h8000};
    logic        dir_c  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        dir_s  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [15:0] dir_es [6] = '{16'h0000, 16'h8000, 16'h7FFF, 16'hFFFE, 16'h0100, 16'h0000};
    logic        dir_ec [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        dir_eo [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    logic [15:0] b2b_a  [8] = '{16'h1234, 16'h00FF, 16'hFFFF, 16'h8000, 16'h0F0F, 16'h1000, 16'hABCD, 16'h7FFF};
    logic [15:0] b2b_b  [8] = '{16'h1111, 16'h0001, 16'h0001, 16'h8000, 16'hF0F0, 16'h2000, 16'h1111, 16'h7FFF};
    logic [15:0] b2b_es [8] = '{16'h2345, 16'h0100, 16'h0000, 16'h0000, 16'hFFFF, 16'h3000, 16'hBCDE, 16'hFFFE};

    always #5 clk = ~clk;

    pipelined_rca_adder #(.WIDTH(16), .SLICE(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    // Reference: plain integer arithmetic on the operands' unsigned and signed values.
    function automatic res_t model(input logic [15:0] x, input logic [15:0] y,
                                   input logic ci, input logic s);
        int   ux;
        int   uy;
        int   sx;
        int   sy;
        int   full;
        int   sres;
        res_t r;
        ux   = int'(x);
        uy   = int'(y);
        sx   = int'($signed(x));
        sy   = int'($signed(y));
        full = s ? (ux - uy) : (ux + uy + int'(ci));
        sres = s ? (sx - sy) : (sx + sy + int'(ci));
        r.sum  = full[15:0];
        r.cout = s ? (ux >= uy) : (full > 65535);
        r.ovf  = (sres > 32767) || (sres < -32768);
        return r;
    endfunction

    // One clock cycle: drive at the falling edge, sample just after, step to the next falling edge.
    task automatic drive(input logic v, input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic tc, input logic ts, input logic ordy,
                         output logic acc, output logic fire, output logic rdy, output res_t got);
        in_valid  = v;
        a         = ta;
        b         = tb_v;
        cin       = tc;
        sub       = ts;
        out_ready = ordy;
        #1;
        rdy  = in_ready;
        acc  = v && in_ready && !rst;
        fire = out_valid && ordy;
        got  = {sum, cout, ovf};
        if (acc) exp_q.push_back(model(ta, tb_v, tc, ts));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        n_checks++;
        if ({sum, cout, ovf} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got sum=%h cout=%b ovf=%b expected all 0", sum, cout, ovf);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic acc, fire, rdy;
        res_t got;
        int   lat;
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, dir_a[i], dir_b[i], dir_c[i], dir_s[i], 1'b1, acc, fire, rdy, got);
            lat = 1;
            while (!out_valid && lat < 20) begin
                drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc, fire, rdy, got);
                lat++;
            end
            n_checks++;
            if (lat != NSTAGE) begin
                n_fail++;
                $display("FAIL dir_latency[%0d]: got %0d cycles expected %0d", i, lat, NSTAGE);
            end
            n_checks++;
            if ({sum, cout, ovf} !== {dir_es[i], dir_ec[i], dir_eo[i]}) begin
                n_fail++;
                $display("FAIL dir_result[%0d]: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                         i, sum, cout, ovf, dir_es[i], dir_ec[i], dir_eo[i]);
            end
            drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc, fire, rdy, got);
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic acc, fire, rdy;
        res_t got;
        res_t exp_r;
        int   sent, nfire, first_cyc, last_cyc;
        exp_q.delete();
        sent = 0; nfire = 0; first_cyc = -1; last_cyc = -1;
        for (int cyc = 0; cyc < 40 && nfire < 8; cyc++) begin
            if (sent < 8)
                drive(1'b1, b2b_a[sent], b2b_b[sent], 1'b0, 1'b0, 1'b1, acc, fire, rdy, got);
            else
                drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc, fire, rdy, got);
            if (acc) sent++;
            if (fire) begin
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                exp_r = exp_q.pop_front();
                n_checks++;
                if (got !== exp_r || got.sum !== b2b_es[nfire]) begin
                    n_fail++;
                    $display("FAIL b2b_result[%0d]: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                             nfire, got.sum, got.cout, got.ovf, b2b_es[nfire], exp_r.cout, exp_r.ovf);
                end
                nfire++;
            end
        end
        n_checks++;
        if (nfire != 8 || (last_cyc - first_cyc) != 7) begin
            n_fail++;
            $display("FAIL b2b_stream: got %0d results over span %0d expected 8 over span 7",
                     nfire, last_cyc - first_cyc);
        end
    endtask

    task automatic test_stall();
        logic acc, fire, rdy;
        res_t got;
        res_t held;
        res_t exp_r;
        int   nfire;
        exp_q.delete();
        for (int i = 0; i < 4; i++)
            drive(1'b1, 16'($urandom()), 16'($urandom()), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'b1, acc, fire, rdy, got);
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_setup: got out_valid=%b expected 1", out_valid);
        end
        held = {sum, cout, ovf};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'($urandom()), 16'($urandom()), 1'b0, 1'b0, 1'b0, acc, fire, rdy, got);
            n_checks++;
            if (rdy !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_in_ready[%0d]: got %b expected 0", i, rdy);
            end
            n_checks++;
            if (got !== held || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got sum=%h valid=%b expected sum=%h valid=1",
                         i, got.sum, out_valid, held.sum);
            end
        end
        nfire = 0;
        for (int cyc = 0; cyc < 20 && nfire < 4; cyc++) begin
            drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc, fire, rdy, got);
            if (fire) begin
                exp_r = exp_q.pop_front();
                n_checks++;
                if (got !== exp_r) begin
                    n_fail++;
                    $display("FAIL stall_drain[%0d]: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                             nfire, got.sum, got.cout, got.ovf, exp_r.sum, exp_r.cout, exp_r.ovf);
                end
                nfire++;
            end
        end
        n_checks++;
        if (nfire != 4 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL stall_count: got %0d results, %0d pending, expected 4 and 0", nfire, exp_q.size());
        end
    endtask

    task automatic test_midreset();
        logic acc, fire, rdy;
        res_t got;
        res_t exp_r;
        int   nfire;
        exp_q.delete();
        for (int i = 0; i < 3; i++)
            drive(1'b1, 16'h1000 + 16'(i), 16'h0101, 1'b0, 1'b0, 1'b1, acc, fire, rdy, got);
        rst       = 1'b1;
        in_valid  = 1'b1;
        a         = 16'h4444;
        b         = 16'h1111;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        n_checks++;
        if (out_valid !== 1'b0 || {sum, cout, ovf} !== 18'h0) begin
            n_fail++;
            $display("FAIL midreset_clear: got valid=%b sum=%h cout=%b ovf=%b expected all 0",
                     out_valid, sum, cout, ovf);
        end
        nfire = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc, fire, rdy, got);
            if (fire) nfire++;
        end
        n_checks++;
        if (nfire != 0) begin
            n_fail++;
            $display("FAIL midreset_discard: got %0d stale results expected 0", nfire);
        end
        drive(1'b1, 16'h2222, 16'h0333, 1'b1, 1'b0, 1'b1, acc, fire, rdy, got);
        nfire = 0;
        for (int i = 0; i < 10 && nfire == 0; i++) begin
            drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc, fire, rdy, got);
            if (fire) begin
                nfire++;
                exp_r = exp_q.pop_front();
                n_checks++;
                if (got !== exp_r) begin
                    n_fail++;
                    $display("FAIL midreset_after: got sum=%h expected sum=%h", got.sum, exp_r.sum);
                end
            end
        end
        n_checks++;
        if (nfire != 1) begin
            n_fail++;
            $display("FAIL midreset_after_timeout: got %0d results expected 1", nfire);
        end
    endtask

    task automatic test_random();
        logic acc, fire, rdy, v, ordy, ov, was_stall, sv, cv;
        logic [15:0] ra, rb;
        res_t got;
        res_t prev;
        res_t exp_r;
        int   sent, recv;
        exp_q.delete();
        sent = 0; recv = 0; was_stall = 1'b0; prev = '0;
        for (int cyc = 0; cyc < 60000 && recv < 10000; cyc++) begin
            v    = (sent < 10000) && ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            ra   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom());
            rb   = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom());
            cv   = 1'($urandom_range(0, 1));
            sv   = 1'($urandom_range(0, 1));
            ov   = out_valid;
            drive(v, ra, rb, cv, sv, ordy, acc, fire, rdy, got);
            if (acc) sent++;
            n_checks++;
            if (rdy !== !(ov && !ordy)) begin
                n_fail++;
                $display("FAIL rand_in_ready[%0d]: got %b expected %b", cyc, rdy, !(ov && !ordy));
            end
            if (was_stall) begin
                n_checks++;
                if (got !== prev || ov !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rand_hold[%0d]: got sum=%h expected held sum=%h", cyc, got.sum, prev.sum);
                end
            end
            if (fire) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_spurious[%0d]: got sum=%h expected no result", cyc, got.sum);
                end else begin
                    exp_r = exp_q.pop_front();
                    if (got !== exp_r) begin
                        n_fail++;
                        $display("FAIL rand_result[%0d]: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                                 recv, got.sum, got.cout, got.ovf, exp_r.sum, exp_r.cout, exp_r.ovf);
                    end
                end
                recv++;
            end
            was_stall = ov && !ordy;
            prev      = got;
        end
        n_checks++;
        if (recv != 10000 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_complete: got %0d results, %0d pending, expected 10000 and 0", recv, exp_q.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_midreset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_rca_adder.md
PIPELINED_RCA_ADDER -- requirements
Module: pipelined_rca_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand/sum width in bits.
REQ-002 Parameter SLICE, default 4: bits added per pipeline stage; WIDTH SHALL be an integer multiple of SLICE, so NSTAGE = WIDTH/SLICE.
REQ-003 Port clk  input  1  rising-edge clock; the block SHALL have one clock, and reset is synchronous and active-high.
REQ-004 Port rst  input  1  synchronous active-high reset.
REQ-005 Port in_valid  input  1  operand transaction present.
REQ-006 Port in_ready  output  1  block accepts the transaction this cycle.
REQ-007 Port a  input  WIDTH  operand A.
REQ-008 Port b  input  WIDTH  operand B.
REQ-009 Port cin  input  1  carry-in, used only when sub=0.
REQ-010 Port sub  input  1  0: a+b+cin; 1: a+~b+1, i.e. a-b.
REQ-011 Port out_valid  output  1  result present.
REQ-012 Port out_ready  input  1  downstream accepts the result.
REQ-013 Port sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-014 Port cout  output  1  carry out of MSB; for sub, 1 means no borrow.
REQ-015 Port ovf  output  1  two's-complement signed overflow of the selected operation.

Function
REQ-016 A transaction SHALL be accepted on a clk edge where in_valid && in_ready.
REQ-017 Stage k (k = 0..NSTAGE-1) SHALL add operand bits [k*SLICE +: SLICE] with the carry registered by stage k-1; stage 0 uses cin, or 1 when sub=1.
REQ-018 Operand slices not yet consumed SHALL be carried forward in skew registers; completed sum slices SHALL be carried forward in deskew registers, so all WIDTH sum bits leave aligned.
REQ-019 Latency SHALL be exactly NSTAGE cycles from the accept edge to out_valid=1 when no stall occurs.
REQ-020 Throughput SHALL be one transaction per cycle; results SHALL emerge in acceptance order.
REQ-021 Stall = out_valid && !out_ready; during a stall every pipeline register SHALL hold its value.
REQ-022 in_ready SHALL equal !stall (combinational); no transaction SHALL be lost or duplicated.
REQ-023 Bubbles (in_valid=0) SHALL propagate as valid=0 stage tokens; a bubble stage's data is don't-care.
REQ-024 sum, cout and ovf SHALL remain stable while out_valid=1 && out_ready=0.
REQ-025 ovf SHALL be computed as carry-into-MSB XOR carry-out-of-MSB of the final stage.
REQ-026 When WIDTH == SLICE (NSTAGE=1), the block SHALL degenerate to a single registered stage with latency 1.

Reset
REQ-027 On a clk edge with rst=1, all stage valid bits SHALL clear, and out_valid, sum, cout and ovf SHALL be 0 from the next cycle.
REQ-028 A reset mid-operation SHALL discard every in-flight transaction; no pre-reset result SHALL appear afterwards.
REQ-029 A transaction presented during the rst=1 cycle SHALL NOT be accepted.

Structure
REQ-030 The NSTAGE computation and the legality check (WIDTH % SLICE == 0, SLICE >= 1) SHALL live in the shared adder constants package/header.
REQ-031 One sub-module, adder_slice (SLICE-bit combinational ripple add with cin and cout, plus carry-into-MSB output), SHALL be instantiated once per stage.

Verification (WIDTH=16, SLICE=4, latency 4)
REQ-032 Inputs a=0xFFFF, b=0x0001, cin=0, sub=0 -> 4 cycles later: sum=0x0000, cout=1, ovf=0.
REQ-033 Inputs a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, cout=0, ovf=1; inputs a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
REQ-034 Stream of 8 back-to-back transactions (0x1234+0x1111, 0x00FF+0x0001, ...) with out_ready=1 -> 8 consecutive valid results in order (0x2345, 0x0100, ...).
REQ-035 out_ready held low for 3 cycles while out_valid=1 -> sum held stable, in_ready=0, and all queued results are delivered in order after release.
REQ-036 rst asserted for one cycle with 3 transactions in flight -> out_valid=0 and sum=0 from the next cycle, and none of the 3 results ever appear.
REQ-037 Randomised run of 10k transactions with random stalls and bubbles, checked against a reference model: zero mismatches.
